// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage and the register file it feeds.
package wb_stage_pkg;

  localparam int WB_DATA_W    = 16;
  localparam int WB_ADDR_W    = 3;
  localparam int WB_LDQ_DEPTH = 2;

  // Register-file write-enable encoding; the register file decodes the same value.
  localparam logic REGWE_WRITE = 1'b1;
  localparam logic REGWE_IDLE  = 1'b0;

  // Per-entry record held by the load-order queue.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic                 kill;
  } ldq_entry_t;

endpackage

// File: rtl/wb_ldq.sv
// In-order load destination queue. Each entry carries the destination register
// and a kill bit; killed entries still occupy a slot so returning data stays
// aligned with its load, but the stage never writes that data.
module wb_ldq #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_dest,
  input  logic                      push_kill,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [ADDR_W-1:0]         kill_addr,
  output logic [ADDR_W-1:0]         head_dest,
  output logic                      head_kill,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      push_drop,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0]          ent_kill,
  output logic [DEPTH*ADDR_W-1:0]   ent_dest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              pop_ok;
  logic              push_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign pop_ok    = pop && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && full && !pop_ok;
  assign head_dest = dest_q[rd_ptr];
  assign head_kill = kill_q[rd_ptr];
  assign ent_kill  = kill_q;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_dest
      assign ent_dest[g*ADDR_W +: ADDR_W] = dest_q[g];
    end
  endgenerate

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, off} < count_q);
    end
  end

  // Storage, pointers and count; kill marking precedes the push so a same-cycle
  // push into a recycled slot carries its own kill value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      kill_q  <= '0;
      for (int i = 0; i < DEPTH; i++) dest_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && ent_valid[i] && (dest_q[i] == kill_addr)) kill_q[i] <= 1'b1;
      end
      if (push_ok) begin
        dest_q[wr_ptr] <= push_dest;
        kill_q[wr_ptr] <= push_kill;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and in-order load returns into the single
// register-file write port, tracks outstanding load destinations and exports a
// busy mask for decode hazard stalls.
// Optional build macro WB_ZERO_REG_EN: register 0 becomes hardwired zero.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = WB_ADDR_W,
  parameter int LDQ_DEPTH = WB_LDQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_issue,
  input  logic [ADDR_W-1:0]        ld_dest,
  output logic                     ld_full,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_rready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     reg_we,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  output logic                     ovf_err
);

  logic [ADDR_W-1:0]           head_dest;
  logic                        head_kill;
  logic [$clog2(LDQ_DEPTH):0]  count;
  logic                        push_drop;
  logic [LDQ_DEPTH-1:0]        ent_valid;
  logic [LDQ_DEPTH-1:0]        ent_kill;
  logic [LDQ_DEPTH*ADDR_W-1:0] ent_dest;
  logic                        xfer;
  logic                        push_kill;
  logic                        alu_we;
  logic                        ld_we;

  // ALU always wins the write port; memory waits by seeing mem_rready low.
  assign mem_rready = ~alu_valid & (count != '0);
  assign xfer       = mem_rvalid & mem_rready;

`ifdef WB_ZERO_REG_EN
  assign alu_we    = (alu_addr != '0);
  assign ld_we     = ~head_kill & (head_dest != '0);
  assign push_kill = (ld_dest == '0);
`else
  assign alu_we    = 1'b1;
  assign ld_we     = ~head_kill;
  assign push_kill = 1'b0;
`endif

  wb_ldq #(
    .DEPTH  (LDQ_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ldq (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_issue),
    .push_dest (ld_dest),
    .push_kill (push_kill),
    .pop       (xfer),
    .kill_en   (alu_valid),
    .kill_addr (alu_addr),
    .head_dest (head_dest),
    .head_kill (head_kill),
    .count     (count),
    .full      (ld_full),
    .push_drop (push_drop),
    .ent_valid (ent_valid),
    .ent_kill  (ent_kill),
    .ent_dest  (ent_dest)
  );

  // Busy bits come from live, unkilled queue entries only.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (ent_valid[i] && !ent_kill[i]) busy_mask[ent_dest[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
`ifdef WB_ZERO_REG_EN
    busy_mask[0] = 1'b0;
`endif
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_addr <= '0;
      wb_data <= '0;
      reg_we  <= REGWE_IDLE;
    end else if (alu_valid) begin
      wb_addr <= alu_addr;
      wb_data <= alu_data;
      reg_we  <= alu_we ? REGWE_WRITE : REGWE_IDLE;
    end else if (xfer) begin
      wb_addr <= head_dest;
      wb_data <= mem_rdata;
      reg_we  <= ld_we ? REGWE_WRITE : REGWE_IDLE;
    end else begin
      reg_we  <= REGWE_IDLE;
    end
  end

  // Sticky overflow flag for a load dropped on a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_err <= 1'b0;
    else if (push_drop) ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected register-file writes are queued
// as stimulus is driven and matched by a monitor as writes appear.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_issue;
  logic [2:0]  ld_dest;
  logic        ld_full;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        mem_rready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        reg_we;
  logic [7:0]  busy_mask;
  logic        ovf_err;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rf [8];
  int          checks = 0;
  int          errors = 0;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_issue   (ld_issue),
    .ld_dest    (ld_dest),
    .ld_full    (ld_full),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rready (mem_rready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .reg_we     (reg_we),
    .busy_mask  (busy_mask),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (reg_we === 1'b1) begin
      rf[wb_addr] = wb_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got addr=%0d data=%h expected no write", wb_addr, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_write got addr=%0d data=%h expected addr=%0d data=%h",
                   wb_addr, wb_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_issue = 0; ld_dest = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wb_addr, wb_data, reg_we, ovf_err, busy_mask, ld_full, mem_rready} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d data=%h we=%b ovf=%b busy=%h full=%b rdy=%b expected all 0",
               wb_addr, wb_data, reg_we, ovf_err, busy_mask, ld_full, mem_rready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_addr = 3; alu_data = 16'hBEEF;
    expect_wr(3, 16'hBEEF);
    tick();
    alu_valid = 0;
    @(negedge clk);
    checks++;
    if (reg_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b expected 1", reg_we); end
    tick();
    @(negedge clk);
    checks++;
    if (reg_we !== 1'b0) begin errors++; $display("FAIL alu_we_drop got %b expected 0", reg_we); end
  endtask

  task automatic test_load();
    ld_issue = 1; ld_dest = 5;
    tick();
    ld_issue = 0;
    mem_rvalid = 1; mem_rdata = 16'h1234;
    expect_wr(5, 16'h1234);
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h20) begin errors++; $display("FAIL load_busy got %h expected 20", busy_mask); end
    checks++;
    if (mem_rready !== 1'b1) begin errors++; $display("FAIL load_rready got %b expected 1", mem_rready); end
    tick();
    mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h00) begin errors++; $display("FAIL load_busy_clear got %h expected 00", busy_mask); end
    checks++;
    if (reg_we !== 1'b1) begin errors++; $display("FAIL load_we got %b expected 1", reg_we); end
  endtask

  task automatic test_alu_priority();
    ld_issue = 1; ld_dest = 7;
    tick();
    ld_issue = 0;
    mem_rvalid = 1; mem_rdata = 16'h7777;
    for (int k = 1; k <= 3; k++) begin
      alu_valid = 1; alu_addr = 3'(k); alu_data = 16'(k * 16'h0101);
      expect_wr(3'(k), 16'(k * 16'h0101));
      @(negedge clk);
      checks++;
      if (mem_rready !== 1'b0) begin errors++; $display("FAIL prio_rready cycle %0d got %b expected 0", k, mem_rready); end
      tick();
    end
    alu_valid = 0;
    expect_wr(7, 16'h7777);
    @(negedge clk);
    checks++;
    if (mem_rready !== 1'b1) begin errors++; $display("FAIL prio_rready_after got %b expected 1", mem_rready); end
    tick();
    mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h00) begin errors++; $display("FAIL prio_busy got %h expected 00", busy_mask); end
    tick();
  endtask

  task automatic test_full_ovf();
    ld_issue = 1; ld_dest = 2;
    tick();
    ld_dest = 4;
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++;
    if (ld_full !== 1'b1) begin errors++; $display("FAIL full_set got %b expected 1", ld_full); end
    checks++;
    if (busy_mask !== 8'h14) begin errors++; $display("FAIL full_busy got %h expected 14", busy_mask); end
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b expected 0", ovf_err); end
    tick();
    ld_issue = 1; ld_dest = 6;
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b expected 1", ovf_err); end
    checks++;
    if (busy_mask !== 8'h14) begin errors++; $display("FAIL ovf_busy got %h expected 14", busy_mask); end
    tick();
    ld_issue = 1; ld_dest = 6; mem_rvalid = 1; mem_rdata = 16'h2222;
    expect_wr(2, 16'h2222);
    tick();
    ld_issue = 0; mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (ld_full !== 1'b1) begin errors++; $display("FAIL full_pushpop got %b expected 1", ld_full); end
    checks++;
    if (busy_mask !== 8'h50) begin errors++; $display("FAIL pushpop_busy got %h expected 50", busy_mask); end
    tick();
    mem_rvalid = 1; mem_rdata = 16'h4444;
    expect_wr(4, 16'h4444);
    tick();
    mem_rdata = 16'h6666;
    expect_wr(6, 16'h6666);
    tick();
    mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({ld_full, busy_mask, ovf_err} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL drain got full=%b busy=%h ovf=%b expected full=0 busy=00 ovf=1", ld_full, busy_mask, ovf_err);
    end
    tick();
  endtask

  task automatic test_waw();
    ld_issue = 1; ld_dest = 6;
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h40) begin errors++; $display("FAIL waw_busy got %h expected 40", busy_mask); end
    tick();
    alu_valid = 1; alu_addr = 6; alu_data = 16'h00AA;
    expect_wr(6, 16'h00AA);
    tick();
    alu_valid = 0;
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h00) begin errors++; $display("FAIL waw_kill_busy got %h expected 00", busy_mask); end
    tick();
    mem_rvalid = 1; mem_rdata = 16'h5555;
    @(negedge clk);
    checks++;
    if (mem_rready !== 1'b1) begin errors++; $display("FAIL waw_rready got %b expected 1", mem_rready); end
    tick();
    mem_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({reg_we, mem_rready} !== 2'b00) begin
      errors++;
      $display("FAIL waw_killed_write got we=%b rdy=%b expected we=0 rdy=0", reg_we, mem_rready);
    end
    checks++;
    if (rf[6] !== 16'h00AA) begin errors++; $display("FAIL waw_r6 got %h expected 00aa", rf[6]); end
    tick();
    // A load pushed alongside an ALU write to the same register is younger and survives.
    alu_valid = 1; alu_addr = 6; alu_data = 16'h0BBB; ld_issue = 1; ld_dest = 6;
    expect_wr(6, 16'h0BBB);
    tick();
    alu_valid = 0; ld_issue = 0;
    @(negedge clk);
    checks++;
    if (busy_mask !== 8'h40) begin errors++; $display("FAIL waw_young_busy got %h expected 40", busy_mask); end
    tick();
    mem_rvalid = 1; mem_rdata = 16'h6060;
    expect_wr(6, 16'h6060);
    tick();
    mem_rvalid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    ld_issue = 1; ld_dest = 2;
    tick();
    ld_dest = 3;
    tick();
    ld_issue = 0;
    mem_rvalid = 1; mem_rdata = 16'hDEAD;
    rst = 1;
    #1;
    checks++;
    if ({wb_addr, wb_data, reg_we, ovf_err, busy_mask, ld_full, mem_rready} !== 30'h0) begin
      errors++;
      $display("FAIL midreset got addr=%0d data=%h we=%b ovf=%b busy=%h full=%b rdy=%b expected all 0",
               wb_addr, wb_data, reg_we, ovf_err, busy_mask, ld_full, mem_rready);
    end
    tick();
    tick();
    rst = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({reg_we, mem_rready} !== 2'b00) begin
      errors++;
      $display("FAIL stale_data got we=%b rdy=%b expected we=0 rdy=0", reg_we, mem_rready);
    end
    mem_rvalid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_alu_priority();
    test_full_ovf();
    test_waw();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
